// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction-fetch / data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    // Transaction phase of the single shared memory port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Which requester owns the current transaction.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Payload presented on the m_* request bus.
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Fetches are always full-word reads.
    function automatic mem_req_t fetch_payload(input logic [ADDR_W-1:0] addr);
        mem_req_t p;
        p.we    = 1'b0;
        p.be    = '1;
        p.addr  = addr;
        p.wdata = '0;
        return p;
    endfunction

    function automatic mem_req_t data_payload(input logic              we,
                                              input logic [BE_W-1:0]   be,
                                              input logic [ADDR_W-1:0] addr,
                                              input logic [DATA_W-1:0] wdata);
        mem_req_t p;
        p.we    = we;
        p.be    = be;
        p.addr  = addr;
        p.wdata = wdata;
        return p;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step on inc, stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter (instruction fetch, data) in front of one single-port
// memory. One transaction outstanding at a time; data has priority unless the
// fetch side has lost STARVE_LIMIT contested arbitrations in a row.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_req,
    output logic              m_we,
    output logic [BE_W-1:0]   m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              busy,
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic              err_spurious
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             err_q, err_d;

    owner_e           sel;          // requester driving m_* this cycle
    logic             fetch_wins;
    logic             conflict_inc;
    mem_req_t         req_bus;

    // Fetch wins if it is alone or has been starved long enough.
    assign fetch_wins = if_req && (!d_req || (starve_q == STV_MAX));

    // Next-state, arbitration, grant and response routing.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        owner_d   = owner_q;
        starve_d  = starve_q;
        err_d     = err_q;
        sel       = OWN_NONE;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;

        // Outputs are forced quiet while reset is held, even though IDLE
        // would otherwise decode live requests combinationally.
        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        sel     = fetch_wins ? OWN_IF : OWN_D;
                        owner_d = sel;
                        state_d = m_ready ? WAIT : ISSUE;
                        if (if_req && d_req && !fetch_wins && (starve_q != STV_MAX)) begin
                            starve_d = starve_q + STV_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    // Owner is locked; newer requests wait their turn.
                    sel     = owner_q;
                    state_d = m_ready ? WAIT : ISSUE;
                end
                WAIT: begin
                    if (m_rvalid) begin
                        if_rvalid = (owner_q == OWN_IF);
                        d_rvalid  = (owner_q == OWN_D);
                        owner_d   = OWN_NONE;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    owner_d = OWN_NONE;
                    state_d = IDLE;
                end
            endcase

            if ((sel != OWN_NONE) && m_ready) begin
                if_gnt = (sel == OWN_IF);
                d_gnt  = (sel == OWN_D);
                if (sel == OWN_IF) begin
                    starve_d = '0;
                end
            end

            // A response with nothing outstanding is a protocol error.
            if (m_rvalid && (state_q != WAIT)) begin
                err_d = 1'b1;
            end
        end
    end

    // Payload mux onto the shared memory request bus.
    always_comb begin
        req_bus = '0;
        unique case (sel)
            OWN_IF:  req_bus = fetch_payload(if_addr);
            OWN_D:   req_bus = data_payload(d_we, d_be, d_addr, d_wdata);
            default: req_bus = '0;
        endcase
    end

    assign m_req   = (sel != OWN_NONE);
    assign m_we    = req_bus.we;
    assign m_be    = req_bus.be;
    assign m_addr  = req_bus.addr;
    assign m_wdata = req_bus.wdata;

    // Read data is a straight pass-through; only rvalid qualifies it.
    assign if_rdata = m_rdata;
    assign d_rdata  = m_rdata;

    assign busy         = (state_q != IDLE);
    assign err_spurious = err_q;

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Contention: both sides asking and neither served this cycle.
    assign conflict_inc = if_req && d_req && !if_gnt && !d_gnt;

    sat_counter #(
        .W (CNT_W)
    ) u_conflict_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (conflict_inc),
        .cnt_o (conflict_cnt)
    );

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus a randomized
// transaction-level run against a behavioural reference model.
module tb_mem_arb;

    localparam int LIM    = 4;
    localparam int CNT_W  = 16;
    localparam int W_NONE = 0;
    localparam int W_IF   = 1;
    localparam int W_D    = 2;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        busy;
    logic [CNT_W-1:0] conflict_cnt;
    logic        err_spurious;

    mem_arb #(
        .STARVE_LIMIT (LIM),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_be         (d_be),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_be         (m_be),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_ready      (m_ready),
        .m_rvalid     (m_rvalid),
        .m_rdata      (m_rdata),
        .busy         (busy),
        .conflict_cnt (conflict_cnt),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending requests as seen by the requesters, plus the
    // arbitration history and the observable counters.
    logic        p_if;
    logic [31:0] if_a;
    logic        p_d;
    logic        d_we_v;
    logic [3:0]  d_be_v;
    logic [31:0] d_a;
    logic [31:0] d_wd;
    int          starve_m;
    int          conf_m;
    logic        err_m;

    int    n_assert;
    int    n_fail;
    string phase;

    int          w;
    int          k;
    int          r;
    logic [31:0] rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    // One clock cycle: drive requesters from the model, drive the memory side,
    // check outputs mid-cycle, update the contention model, advance.
    task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rdat,
                       input int m_who, input int gnt_who, input int rv_who, input bit busy_x);
        if_req   = p_if;
        if_addr  = if_a;
        d_req    = p_d;
        d_we     = d_we_v;
        d_be     = d_be_v;
        d_addr   = d_a;
        d_wdata  = d_wd;
        m_ready  = rdy;
        m_rvalid = rv;
        m_rdata  = rdat;
        #1;
        check("m_req", m_req, m_who != W_NONE);
        if (m_who == W_IF) begin
            check("m_addr", m_addr, if_a);
            check("m_we", m_we, 1'b0);
            check("m_be", m_be, 4'hF);
            check("m_wdata", m_wdata, 32'h0);
        end else if (m_who == W_D) begin
            check("m_addr", m_addr, d_a);
            check("m_we", m_we, d_we_v);
            check("m_be", m_be, d_be_v);
            check("m_wdata", m_wdata, d_wd);
        end
        check("if_gnt", if_gnt, gnt_who == W_IF);
        check("d_gnt", d_gnt, gnt_who == W_D);
        check("if_rvalid", if_rvalid, rv_who == W_IF);
        check("d_rvalid", d_rvalid, rv_who == W_D);
        if (rv_who == W_IF) check("if_rdata", if_rdata, rdat);
        if (rv_who == W_D)  check("d_rdata", d_rdata, rdat);
        check("busy", busy, busy_x);
        check("conflict_cnt", conflict_cnt, conf_m);
        check("err_spurious", err_spurious, err_m);
        if (p_if && p_d && (gnt_who == W_NONE) && (conf_m < 65535)) conf_m++;
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, verify the asynchronous effect, release on the next negedge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_m_req", m_req, 1'b0);
        check("rst_if_gnt", if_gnt, 1'b0);
        check("rst_d_gnt", d_gnt, 1'b0);
        check("rst_if_rvalid", if_rvalid, 1'b0);
        check("rst_d_rvalid", d_rvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_conflict", conflict_cnt, 16'h0);
        check("rst_err", err_spurious, 1'b0);
        p_if     = 1'b0;
        p_d      = 1'b0;
        starve_m = 0;
        conf_m   = 0;
        err_m    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        phase    = "reset";
        if_a = 32'h0; d_we_v = 1'b0; d_be_v = 4'h0; d_a = 32'h0; d_wd = 32'h0;
        // Live requests during reset must not leak onto m_req or grants.
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b0;
        d_be = 4'hF; d_addr = 32'h8; d_wdata = 32'h0;
        m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = 32'h0;
        @(negedge clk);
        do_reset();

        // Lone fetch, zero-wait memory, one-cycle response.
        phase = "fetch_only";
        p_if = 1'b1; if_a = 32'h10;
        cyc(1, 0, 32'h0, W_IF, W_IF, W_NONE, 0);
        p_if = 1'b0;
        cyc(1, 1, 32'h00500093, W_NONE, W_NONE, W_IF, 1);

        // Both always requesting: D,D,D,D,IF repeating, contention only in WAIT.
        phase = "starve";
        p_if = 1'b1; if_a = 32'h40;
        p_d = 1'b1; d_we_v = 1'b0; d_be_v = 4'hF; d_a = 32'h200; d_wd = 32'h0;
        for (int t = 0; t < 10; t++) begin
            w = ((t % 5) == 4) ? W_IF : W_D;
            cyc(1, 0, 32'h0, w, w, W_NONE, 0);
            cyc(1, 1, 32'hA000_0000 + 32'(t), W_NONE, W_NONE, w, 1);
        end
        p_if = 1'b0; p_d = 1'b0;
        cyc(1, 0, 32'h0, W_NONE, W_NONE, W_NONE, 0);

        // Data write held off by m_ready for three cycles.
        phase = "write_stall";
        p_d = 1'b1; d_we_v = 1'b1; d_be_v = 4'b0011; d_a = 32'h100; d_wd = 32'hDEADBEEF;
        cyc(0, 0, 32'h0, W_D, W_NONE, W_NONE, 0);
        cyc(0, 0, 32'h0, W_D, W_NONE, W_NONE, 1);
        cyc(0, 0, 32'h0, W_D, W_NONE, W_NONE, 1);
        cyc(1, 0, 32'h0, W_D, W_D, W_NONE, 1);
        p_d = 1'b0;
        cyc(0, 0, 32'h0, W_NONE, W_NONE, W_NONE, 1);
        cyc(0, 1, 32'h0, W_NONE, W_NONE, W_D, 1);

        // Fetch latched in ISSUE keeps the port when data arrives later.
        phase = "issue_lock";
        p_if = 1'b1; if_a = 32'h20;
        cyc(0, 0, 32'h0, W_IF, W_NONE, W_NONE, 0);
        p_d = 1'b1; d_we_v = 1'b0; d_be_v = 4'hF; d_a = 32'h300; d_wd = 32'h0;
        cyc(0, 0, 32'h0, W_IF, W_NONE, W_NONE, 1);
        cyc(1, 0, 32'h0, W_IF, W_IF, W_NONE, 1);
        p_if = 1'b0;
        cyc(0, 1, 32'h1234_5678, W_NONE, W_NONE, W_IF, 1);
        cyc(1, 0, 32'h0, W_D, W_D, W_NONE, 0);
        p_d = 1'b0;
        cyc(0, 1, 32'h8765_4321, W_NONE, W_NONE, W_D, 1);

        // Randomized transactions against the model.
        phase = "random";
        do_reset();
        for (int t = 0; t < 300; t++) begin
            if (!p_if && ($urandom_range(0, 1) == 1)) begin
                p_if = 1'b1; if_a = $urandom;
            end
            if (!p_d && ($urandom_range(0, 1) == 1)) begin
                p_d = 1'b1; d_we_v = 1'($urandom); d_be_v = 4'($urandom);
                d_a = $urandom; d_wd = $urandom;
            end
            if (!p_if && !p_d) begin
                cyc(1'($urandom), 0, 32'h0, W_NONE, W_NONE, W_NONE, 0);
                continue;
            end
            // Data has priority unless fetch has lost LIM contested rounds.
            w = (p_if && (!p_d || (starve_m == LIM))) ? W_IF : W_D;
            if (p_if && p_d && (w == W_D) && (starve_m < LIM)) starve_m++;
            k = $urandom_range(0, 2);
            for (int i = 0; i < k; i++) cyc(0, 0, 32'h0, w, W_NONE, W_NONE, i != 0);
            cyc(1, 0, 32'h0, w, w, W_NONE, k != 0);
            if (w == W_IF) begin
                starve_m = 0;
                p_if = 1'b0;
                if ($urandom_range(0, 1) == 1) begin p_if = 1'b1; if_a = $urandom; end
            end else begin
                p_d = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    p_d = 1'b1; d_we_v = 1'($urandom); d_be_v = 4'($urandom);
                    d_a = $urandom; d_wd = $urandom;
                end
            end
            r = $urandom_range(0, 2);
            for (int i = 0; i < r; i++) cyc(1'($urandom), 0, 32'h0, W_NONE, W_NONE, W_NONE, 1);
            rd = $urandom;
            cyc(1'($urandom), 1, rd, W_NONE, W_NONE, w, 1);
        end

        // Reset while WAITing; the late response is spurious.
        phase = "reset_in_wait";
        do_reset();
        p_d = 1'b1; d_we_v = 1'b0; d_be_v = 4'hF; d_a = 32'h400; d_wd = 32'h0;
        cyc(1, 0, 32'h0, W_D, W_D, W_NONE, 0);
        p_d = 1'b0;
        if_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b0;
        do_reset();
        cyc(0, 1, 32'hBAD0_BAD0, W_NONE, W_NONE, W_NONE, 0);
        err_m = 1'b1;
        cyc(0, 0, 32'h0, W_NONE, W_NONE, W_NONE, 0);
        cyc(0, 0, 32'h0, W_NONE, W_NONE, W_NONE, 0);

        // Conflict counter saturation.
        phase = "saturate";
        do_reset();
        p_if = 1'b1; if_a = 32'h50;
        p_d = 1'b1; d_we_v = 1'b0; d_be_v = 4'hF; d_a = 32'h500; d_wd = 32'h0;
        cyc(0, 0, 32'h0, W_D, W_NONE, W_NONE, 0);
        for (int i = 0; i < 65534; i++) @(negedge clk);
        conf_m = 65535;
        cyc(0, 0, 32'h0, W_D, W_NONE, W_NONE, 1);
        cyc(0, 0, 32'h0, W_D, W_NONE, W_NONE, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive contested losses by fetch before fetch is forced to win.
REQ-002 Parameter: CNT_W, default 16, width of conflict counter.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1; if_addr  in  32: fetch request and word address, held stable until if_gnt.
REQ-006 if_gnt  out  1; if_rvalid  out  1; if_rdata  out  32: fetch grant pulse, response pulse, response data.
REQ-007 d_req  in  1; d_we  in  1; d_be  in  4; d_addr  in  32; d_wdata  in  32: data request, held stable until d_gnt.
REQ-008 d_gnt  out  1; d_rvalid  out  1; d_rdata  out  32: data grant pulse, response pulse (reads and writes), read data.
REQ-009 m_req  out  1; m_we  out  1; m_be  out  4; m_addr  out  32; m_wdata  out  32: shared single-port memory request.
REQ-010 m_ready  in  1; m_rvalid  in  1; m_rdata  in  32: memory accept, response pulse, read data.
REQ-011 busy  out  1; conflict_cnt  out  CNT_W; err_spurious  out  1: activity, contention count, sticky error.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT; exactly one transaction outstanding at any time.
REQ-013 IDLE, no request: m_req=0, stay IDLE.
REQ-014 IDLE, any request: winner chosen combinationally, winner's payload driven to m_* with m_req=1 in the same cycle.
REQ-015 Arbitration: data wins over fetch, except fetch wins when starve counter equals STARVE_LIMIT.
REQ-016 Starve counter: +1 when both requests present and data wins; cleared when fetch is granted; never exceeds STARVE_LIMIT.
REQ-017 m_ready=1 with m_req=1: one-cycle gnt pulse to owner that cycle, next state WAIT.
REQ-018 m_ready=0 in IDLE: owner latched, next state ISSUE; ISSUE holds same owner and payload, m_req=1, until m_ready, then gnt pulse, next WAIT; later higher-priority requests ignored.
REQ-019 WAIT: m_req=0; on m_rvalid, m_rdata forwarded to owner's rdata and owner's rvalid pulses that cycle (zero-latency pass-through), next IDLE.
REQ-020 Non-owner rvalid is 0 at all times; rdata outputs are don't-care when rvalid=0.
REQ-021 Fetch payload drives m_we=0, m_be=4'hF, m_wdata=0.
REQ-022 Minimum throughput: one transaction per two cycles (grant cycle, response cycle).
REQ-023 conflict_cnt increments in every cycle with if_req=1 and d_req=1 and no gnt to either; saturates at all-ones.
REQ-024 m_rvalid in IDLE or ISSUE: ignored for routing, err_spurious set and held until reset.
REQ-025 busy=1 whenever state is not IDLE.

Reset
REQ-026 rst low: state IDLE, owner cleared, starve counter 0, conflict_cnt 0, err_spurious 0, all gnt/rvalid/m_req 0, immediately and asynchronously.
REQ-027 Reset during ISSUE or WAIT discards the transaction; no rvalid is produced for it; a late m_rvalid after reset sets err_spurious.

Structure
REQ-028 Package mem_arb_pkg holds state enum (IDLE/ISSUE/WAIT), owner enum (OWN_NONE/OWN_IF/OWN_D) and 32-bit address/data width constants.
REQ-029 One sub-module, sat_counter (parameterised width, inc, async active-low clear), used for conflict_cnt.

Verification
REQ-030 Fetch only, if_addr=0x10, m_ready=1, m_rvalid one cycle later with m_rdata=0x00500093 -> if_gnt pulse cycle 0, if_rvalid with if_rdata=0x00500093 cycle 1, d_gnt never.
REQ-031 Both request every cycle, m_ready=1, 1-cycle memory -> grant order D,D,D,D,IF repeating with STARVE_LIMIT=4; conflict_cnt increments only in WAIT cycles.
REQ-032 Data write d_addr=0x100, d_be=4'b0011, d_wdata=0xDEADBEEF, m_ready low 3 cycles -> m_* stable over all 4 cycles, d_gnt pulses on 4th, d_rvalid on m_rvalid.
REQ-033 Fetch latched in ISSUE (m_ready=0), d_req rises next cycle -> fetch still granted first, data granted after fetch response.
REQ-034 rst low in WAIT, m_rvalid arrives after release -> no rvalid to either port, err_spurious=1, state IDLE.
REQ-035 Force 0xFFFF contested cycles then one more -> conflict_cnt stays 0xFFFF.
